// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified backing-memory port between the instruction fetch path
// (imem_*) and the load/store path (dmem_*) of a pipelined RV32I core.
// At most one transaction is outstanding. A granted request is forwarded to
// memory as a registered, single-cycle mask pulse, and the memory response is
// routed combinationally back to the requester that owns it.
//
// Arbitration (sampled only in IDLE):
//   - dmem wins when both are pending, unless dmem has already been granted
//     MAX_D_STREAK times in a row while imem was waiting; imem is then forced.
//
// Handshake: a requester raises a nonzero mask and holds address, masks and
// data stable until it sees its one-cycle resp. Requests are only looked at
// in IDLE, so a request still held during the resp cycle is never re-issued;
// whatever is presented in the cycle after resp is treated as a new request.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_addr/rmask               fetch request (pending when rmask != 0)
//   imem_rdata/resp               fetch completion (rdata is 0 unless resp)
//   dmem_addr/rmask/wmask/wdata   load/store request (pending when any mask != 0)
//   dmem_rdata/resp               load/store completion (rdata is 0 unless resp)
//   mem_addr/rmask/wmask/wdata    registered request to backing memory
//   mem_rdata/resp                backing memory response
//   dbg_state                     FSM state: 0 IDLE, 1 ISSUE_I, 2 ISSUE_D,
//                                 3 WAIT_I, 4 WAIT_D
//   dbg_d_streak                  consecutive dmem grants made while imem waited
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned MAX_D_STREAK = 4  // legal range 1..15
) (
    input  logic        clk,
    input  logic        rst,

    // Fetch port
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,

    // Load/store port
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,

    // Backing memory port
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp,

    // Debug visibility
    output logic [2:0]  dbg_state,
    output logic [3:0]  dbg_d_streak
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE_I = 3'd1,
        ISSUE_D = 3'd2,
        WAIT_I  = 3'd3,
        WAIT_D  = 3'd4
    } state_t;

    localparam logic [3:0] MAX_STREAK = 4'(MAX_D_STREAK);

    // -----------------------------------------------------------------------
    // State and registered memory request
    // -----------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [3:0]  d_streak_q,  d_streak_d;
    logic [31:0] mem_addr_q,  mem_addr_d;
    logic [3:0]  mem_rmask_q, mem_rmask_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    // -----------------------------------------------------------------------
    // Request decode and arbitration
    // -----------------------------------------------------------------------
    logic imem_pend;
    logic dmem_pend;
    logic streak_full;
    logic grant_i;
    logic grant_d;

    always_comb begin
        imem_pend   = (imem_rmask != 4'h0);
        dmem_pend   = (dmem_rmask != 4'h0) || (dmem_wmask != 4'h0);
        streak_full = (d_streak_q >= MAX_STREAK);
        // imem only wins a tie once dmem has used up its streak allowance.
        grant_i     = (state_q == IDLE) && imem_pend && (!dmem_pend || streak_full);
        grant_d     = (state_q == IDLE) && dmem_pend && !(imem_pend && streak_full);
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        d_streak_d  = d_streak_q;
        mem_addr_d  = mem_addr_q;
        mem_rmask_d = mem_rmask_q;
        mem_wmask_d = mem_wmask_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            IDLE: begin
                // A stale mem_resp seen here is simply ignored.
                if (grant_d) begin
                    state_d     = ISSUE_D;
                    mem_addr_d  = dmem_addr;
                    mem_rmask_d = dmem_rmask;
                    mem_wmask_d = dmem_wmask;
                    mem_wdata_d = dmem_wdata;
                    // The streak only counts grants that made imem wait.
                    if (imem_pend) begin
                        d_streak_d = streak_full ? MAX_STREAK : d_streak_q + 4'd1;
                    end else begin
                        d_streak_d = 4'd0;
                    end
                end else if (grant_i) begin
                    state_d     = ISSUE_I;
                    mem_addr_d  = imem_addr;
                    mem_rmask_d = imem_rmask;
                    mem_wmask_d = 4'h0;
                    mem_wdata_d = 32'h0;
                    d_streak_d  = 4'd0;
                end
            end

            // The masks are live for exactly the ISSUE cycle; address and
            // write data keep their last value afterwards.
            ISSUE_I: begin
                state_d     = WAIT_I;
                mem_rmask_d = 4'h0;
                mem_wmask_d = 4'h0;
            end

            ISSUE_D: begin
                state_d     = WAIT_D;
                mem_rmask_d = 4'h0;
                mem_wmask_d = 4'h0;
            end

            WAIT_I: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end

            WAIT_D: begin
                if (mem_resp) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            d_streak_q  <= 4'd0;
            mem_addr_q  <= 32'h0;
            mem_rmask_q <= 4'h0;
            mem_wmask_q <= 4'h0;
            mem_wdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            d_streak_q  <= d_streak_d;
            mem_addr_q  <= mem_addr_d;
            mem_rmask_q <= mem_rmask_d;
            mem_wmask_q <= mem_wmask_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    always_comb begin
        mem_addr     = mem_addr_q;
        mem_rmask    = mem_rmask_q;
        mem_wmask    = mem_wmask_q;
        mem_wdata    = mem_wdata_q;

        // Responses are steered by the WAIT state, so only the owner of the
        // in-flight transaction can ever see a resp pulse.
        imem_resp    = (state_q == WAIT_I) && mem_resp;
        dmem_resp    = (state_q == WAIT_D) && mem_resp;
        imem_rdata   = imem_resp ? mem_rdata : 32'h0;
        dmem_rdata   = dmem_resp ? mem_rdata : 32'h0;

        dbg_state    = state_q;
        dbg_d_streak = d_streak_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Random and directed traffic on both requester ports against a behavioural
// memory with variable latency. Drivers push the expected memory request and
// the expected response into queues; one monitor pops and compares whenever
// the DUT pulses a memory request or a resp. Arbitration is judged from the
// pending status seen in the cycle before each memory pulse.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int         MAX       = 4;
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WAIT_D = 3'd4;

    // clock / reset
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] imem_addr, imem_rdata;
    logic [3:0]  imem_rmask;
    logic        imem_resp;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_rmask, dmem_wmask;
    logic        dmem_resp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_rmask, mem_wmask;
    logic        mem_resp;
    logic [2:0]  dbg_state;
    logic [3:0]  dbg_d_streak;

    mem_port_arbiter #(.MAX_D_STREAK(MAX)) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_rmask   (imem_rmask),
        .imem_rdata   (imem_rdata),
        .imem_resp    (imem_resp),
        .dmem_addr    (dmem_addr),
        .dmem_rmask   (dmem_rmask),
        .dmem_wmask   (dmem_wmask),
        .dmem_wdata   (dmem_wdata),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp),
        .mem_addr     (mem_addr),
        .mem_rmask    (mem_rmask),
        .mem_wmask    (mem_wmask),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_resp     (mem_resp),
        .dbg_state    (dbg_state),
        .dbg_d_streak (dbg_d_streak)
    );

    // scoreboard state
    int total = 0;
    int bad   = 0;

    logic [35:0] ireq_q[$];   // {rmask, addr}
    logic [71:0] dreq_q[$];   // {rmask, wmask, wdata, addr}
    logic [31:0] iexp_q[$];   // expected fetch data
    logic [32:0] dexp_q[$];   // {is_store, expected load data}
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] bmem[logic [31:0]];
    int          grant_log[$];   // 0 = imem, 1 = dmem
    int          pulse_cyc_q[$];
    int          iresp_cyc_q[$];
    int          lat_lo    = 1;
    int          lat_hi    = 1;
    int          stale_req = 0;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    // behavioural backing memory
    initial begin
        logic [31:0] w;
        int lat;
        int stale_done;
        stale_done = 0;
        mem_resp   = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if ((mem_rmask | mem_wmask) != 4'h0) begin
                if (mem_addr == 32'h1000_0000) w = 32'h0000_0013;
                else if (bmem.exists(mem_addr)) w = bmem[mem_addr];
                else w = init_word(mem_addr);
                for (int b = 0; b < 4; b++)
                    if (mem_wmask[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
                if (mem_wmask != 4'h0) bmem[mem_addr] = w;
                lat = $urandom_range(lat_hi, lat_lo);
                repeat (lat) @(posedge clk);
                #1 mem_resp = 1'b1; mem_rdata = w;
                @(posedge clk);
                #1 mem_resp = 1'b0; mem_rdata = $urandom();
            end else if (stale_req != stale_done) begin
                stale_done++;
                @(posedge clk);
                #1 mem_resp = 1'b1; mem_rdata = 32'hBAD0_BAD0;
                @(posedge clk);
                #1 mem_resp = 1'b0; mem_rdata = $urandom();
            end
        end
    end

    // monitor
    initial begin
        int cyc, last_resp, streak_m;
        bit prev_ip, prev_dp, prev_pulse, rst_prev, pulse, is_i, exp_i;
        logic [35:0] ir;
        logic [71:0] dr;
        logic [32:0] de;
        cyc = 0; last_resp = -100; streak_m = 0;
        prev_ip = 0; prev_dp = 0; prev_pulse = 0; rst_prev = 0;
        forever begin
            @(negedge clk);
            cyc++;
            pulse = ((mem_rmask | mem_wmask) != 4'h0);
            if (rst_prev) begin
                check("rst_mem_addr", 72'(mem_addr), 72'(0));
                check("rst_mem_ctl", 72'({mem_rmask, mem_wmask, mem_wdata}), 72'(0));
                check("rst_resp", 72'({imem_resp, dmem_resp, imem_rdata, dmem_rdata}), 72'(0));
                check("rst_state", 72'({dbg_state, dbg_d_streak}), 72'(0));
                streak_m = 0;
            end
            if (pulse && !rst_prev) begin
                check("pulse_one_cycle", 72'(prev_pulse), 72'(0));
                check("issue_after_resp", 72'((cyc - last_resp) >= 2), 72'(1));
                is_i  = mem_addr[28];
                exp_i = prev_ip && (!prev_dp || streak_m == MAX);
                check("grant_winner", 72'(is_i), 72'(exp_i));
                if (is_i) streak_m = 0;
                else if (prev_ip) streak_m = (streak_m < MAX) ? streak_m + 1 : MAX;
                else streak_m = 0;
                check("d_streak", 72'(dbg_d_streak), 72'(streak_m));
                grant_log.push_back(is_i ? 0 : 1);
                pulse_cyc_q.push_back(cyc);
                if (is_i) begin
                    check("i_issue_expected", 72'(ireq_q.size() > 0), 72'(1));
                    if (ireq_q.size() > 0) begin
                        ir = ireq_q.pop_front();
                        check("i_issue", {mem_rmask, mem_wmask, mem_wdata, mem_addr},
                              {ir[35:32], 4'h0, 32'h0, ir[31:0]});
                    end
                end else begin
                    check("d_issue_expected", 72'(dreq_q.size() > 0), 72'(1));
                    if (dreq_q.size() > 0) begin
                        dr = dreq_q.pop_front();
                        check("d_issue", {mem_rmask, mem_wmask, mem_wdata, mem_addr}, dr);
                    end
                end
            end
            if (imem_resp || dmem_resp)
                check("resp_exclusive", 72'(imem_resp & dmem_resp), 72'(0));
            if (imem_resp) begin
                last_resp = cyc;
                iresp_cyc_q.push_back(cyc);
                check("imem_resp_expected", 72'(iexp_q.size() > 0), 72'(1));
                if (iexp_q.size() > 0) check("imem_rdata", 72'(imem_rdata), 72'(iexp_q.pop_front()));
            end else begin
                check("imem_rdata_idle", 72'(imem_rdata), 72'(0));
            end
            if (dmem_resp) begin
                last_resp = cyc;
                check("dmem_resp_expected", 72'(dexp_q.size() > 0), 72'(1));
                if (dexp_q.size() > 0) begin
                    de = dexp_q.pop_front();
                    if (!de[32]) check("dmem_rdata", 72'(dmem_rdata), 72'(de[31:0]));
                end
            end else begin
                check("dmem_rdata_idle", 72'(dmem_rdata), 72'(0));
            end
            prev_ip    = (imem_rmask != 4'h0);
            prev_dp    = ((dmem_rmask | dmem_wmask) != 4'h0);
            prev_pulse = pulse;
            rst_prev   = rst;
        end
    end

    // driver tasks
    task automatic do_i(input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] exp, input bit drop);
        int n;
        @(posedge clk);
        #1 imem_addr = a; imem_rmask = m;
        ireq_q.push_back({m, a});
        iexp_q.push_back(exp);
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (imem_resp) break;
        end
        check("imem_done", 72'(imem_resp), 72'(1));
        if (drop) begin
            @(posedge clk);
            #1 imem_rmask = 4'h0;
        end
    endtask

    task automatic do_d(input logic [31:0] a, input logic [3:0] rm, input logic [3:0] wm,
                        input logic [31:0] wd, input bit drop);
        int n;
        logic [31:0] w;
        @(posedge clk);
        #1 dmem_addr = a; dmem_rmask = rm; dmem_wmask = wm; dmem_wdata = wd;
        dreq_q.push_back({rm, wm, wd, a});
        if (wm != 4'h0) begin
            w = ref_read(a);
            for (int b = 0; b < 4; b++)
                if (wm[b]) w[b*8 +: 8] = wd[b*8 +: 8];
            ref_mem[a] = w;
            dexp_q.push_back({1'b1, 32'h0});
        end else begin
            dexp_q.push_back({1'b0, ref_read(a)});
        end
        n = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (dmem_resp) break;
        end
        check("dmem_done", 72'(dmem_resp), 72'(1));
        if (drop) begin
            @(posedge clk);
            #1 dmem_rmask = 4'h0; dmem_wmask = 4'h0;
        end
    endtask

    task automatic run_i(input int n, input int max_gap);
        logic [31:0] a;
        int gap;
        for (int i = 0; i < n; i++) begin
            a   = 32'h1000_0100 + (32'($urandom_range(0, 63)) << 2);
            gap = $urandom_range(0, max_gap);
            do_i(a, 4'($urandom_range(1, 15)), init_word(a), (gap != 0) || (i == n - 1));
            if (gap > 1) repeat (gap - 1) @(posedge clk);
        end
    endtask

    task automatic run_d(input int n, input int max_gap);
        logic [31:0] a;
        int gap;
        bit drop;
        for (int i = 0; i < n; i++) begin
            a    = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
            gap  = $urandom_range(0, max_gap);
            drop = (gap != 0) || (i == n - 1);
            if ($urandom_range(0, 1) == 1)
                do_d(a, 4'($urandom_range(1, 15)), 4'h0, $urandom(), drop);
            else
                do_d(a, 4'h0, 4'($urandom_range(1, 15)), $urandom(), drop);
            if (gap > 1) repeat (gap - 1) @(posedge clk);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // main sequence
    initial begin
        int n;
        rst = 1'b1;
        imem_addr = 32'h0; imem_rmask = 4'h0;
        dmem_addr = 32'h0; dmem_rmask = 4'h0; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // stale response with nothing pending
        stale_req++;
        repeat (6) @(negedge clk);
        check("stale_state", 72'(dbg_state), 72'(ST_IDLE));
        check("stale_streak", 72'(dbg_d_streak), 72'(0));

        // single fetch, memory answers two cycles after the pulse
        lat_lo = 2; lat_hi = 2;
        do_i(32'h1000_0000, 4'hF, 32'h0000_0013, 1'b1);

        // store, then read it back
        do_d(32'h0000_0020, 4'h0, 4'h3, 32'hDEAD_BEEF, 1'b1);
        do_d(32'h0000_0020, 4'hF, 4'h0, 32'h0, 1'b1);

        // fetch request held through its resp with a new address
        lat_lo = 1; lat_hi = 3;
        repeat (3) @(posedge clk);
        pulse_cyc_q.delete();
        iresp_cyc_q.delete();
        do_i(32'h1000_0100, 4'hF, init_word(32'h1000_0100), 1'b0);
        do_i(32'h1000_0004, 4'hF, init_word(32'h1000_0004), 1'b1);
        repeat (3) @(posedge clk);
        check("held_issue_count", 72'(pulse_cyc_q.size()), 72'(2));
        if (pulse_cyc_q.size() >= 2 && iresp_cyc_q.size() >= 1)
            check("held_issue_gap", 72'(pulse_cyc_q[1] - iresp_cyc_q[0]), 72'(2));

        // reset while a load waits for memory
        lat_lo = 3; lat_hi = 3;
        @(posedge clk);
        #1 dmem_addr = 32'h0000_0040; dmem_rmask = 4'hF; dmem_wmask = 4'h0; dmem_wdata = 32'h0;
        dreq_q.push_back({4'hF, 4'h0, 32'h0, 32'h0000_0040});
        dexp_q.push_back({1'b0, ref_read(32'h0000_0040)});
        n = 0;
        while (n < 50) begin
            @(negedge clk);
            n++;
            if (dbg_state == ST_WAIT_D) break;
        end
        check("reach_wait_d", 72'(dbg_state), 72'(ST_WAIT_D));
        @(posedge clk);
        #1 rst = 1'b1; dmem_rmask = 4'h0;
        if (dexp_q.size() > 0) void'(dexp_q.pop_back());
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        do_d(32'h0000_0040, 4'hF, 4'h0, 32'h0, 1'b1);

        // contention with 1-cycle memory
        lat_lo = 1; lat_hi = 1;
        pulse_reset();
        repeat (2) @(posedge clk);
        grant_log.delete();
        fork
            run_i(2, 0);
            run_d(8, 0);
        join
        repeat (3) @(posedge clk);
        check("contention_count", 72'(grant_log.size()), 72'(10));
        for (int k = 0; k < 10; k++)
            if (k < grant_log.size())
                check("contention_order", 72'(grant_log[k]), 72'((k % (MAX + 1) == MAX) ? 0 : 1));

        // random traffic
        lat_lo = 1; lat_hi = 3;
        fork
            run_i(30, 3);
            run_d(40, 3);
        join

        n = 0;
        while ((iexp_q.size() + dexp_q.size() + ireq_q.size() + dreq_q.size()) != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 72'(iexp_q.size() + dexp_q.size() + ireq_q.size() + dreq_q.size()), 72'(0));

        repeat (4) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single unified memory port between the fetch path (`imem_*`) and the load/store path (`dmem_*`) of the pipelined RV32I core. It accepts at most one outstanding transaction and forwards it to the backing memory as a registered one-cycle request. It routes the response back to the owning requester and keeps the pipeline's stall signals correct. Data requests normally win; a streak limiter prevents fetch starvation.

## Interface
Parameters:
- MAX_D_STREAK, 4: consecutive dmem grants allowed while imem is waiting, before imem is forced. Legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- imem_addr  in  32  fetch address (word aligned).
- imem_rmask  in  4  fetch request; nonzero means pending, held stable until imem_resp.
- imem_rdata  out  32  fetch data; valid only while imem_resp=1.
- imem_resp  out  1  one-cycle fetch completion.
- dmem_addr  in  32  load/store address (word aligned).
- dmem_rmask  in  4  load byte mask.
- dmem_wmask  in  4  store byte mask. A request is pending when rmask or wmask is nonzero; it is held stable until dmem_resp.
- dmem_wdata  in  32  store data.
- dmem_rdata  out  32  load data; valid only while dmem_resp=1.
- dmem_resp  out  1  one-cycle load/store completion.
- mem_addr  out  32  backing memory address (registered).
- mem_rmask  out  4  backing memory read mask (registered).
- mem_wmask  out  4  backing memory write mask (registered).
- mem_wdata  out  32  backing memory write data (registered).
- mem_rdata  in  32  backing memory read data.
- mem_resp  in  1  backing memory completion; arrives at least 1 cycle after the request pulse.

## Operation
- FSM states: IDLE, ISSUE_I, ISSUE_D, WAIT_I, WAIT_D.
- IDLE arbitration, sampled each cycle:
  - Only dmem pending → dmem.
  - Only imem pending → imem.
  - Both pending → dmem, unless d_streak == MAX_D_STREAK, in which case imem.
- On grant:
  - Latch addr, masks and wdata into the mem_* output registers. Imem grants use rmask=imem_rmask, wmask=0, wdata=0.
  - Go to ISSUE_x.
- ISSUE_x: mem_* masks are nonzero for exactly this cycle. Go to WAIT_x. A mem_resp in this cycle is legal only if memory is combinational; it is not required to be handled and must never occur.
- WAIT_x:
  - mem_* masks are 0 (addr/wdata hold their last value).
  - On mem_resp: x_resp=1 and x_rdata=mem_rdata combinationally in the same cycle, then go to IDLE.
  - The other requester's resp stays 0.
- Requests presented while not in IDLE are not sampled. A requester still holding its old request in its resp cycle is therefore never re-issued.
- d_streak (4 bits):
  - Increments on each dmem grant made while imem was pending.
  - Clears on any imem grant, and on any dmem grant made with imem not pending.
  - Saturates at MAX_D_STREAK.
- mem_resp in IDLE (stale, e.g. after reset) is dropped; no x_resp is generated.
- imem_rdata/dmem_rdata drive 0 when the matching resp is 0.
- Write response: dmem_resp pulses and dmem_rdata is don't-care (driven 0 is acceptable, but mem_rdata passthrough is also allowed).

## Timing
- Reset values:
  - state=IDLE, d_streak=0.
  - mem_addr=0, mem_rmask=0, mem_wmask=0, mem_wdata=0.
  - imem_resp=0, dmem_resp=0, imem_rdata=0, dmem_rdata=0.
- Latency: request seen in IDLE at cycle t → mem masks nonzero at t+1 only → x_resp in the cycle mem_resp arrives (≥ t+2) → IDLE at resp+1. The earliest next grant is sampled at resp+1 and issued at resp+2.
- Minimum turnaround is 3 cycles per transaction with 1-cycle memory latency.
- rst asserted mid-transaction: next cycle is IDLE with all outputs at reset values. The in-flight mem_resp is dropped, and requesters must re-present their requests.
- Simultaneous new requests from both sides in the same IDLE cycle follow the arbitration rule; the loser keeps waiting with no glitch on its resp.

## Test plan
- Single fetch: imem_rmask=4'hF, addr=0x1000_0000; memory returns 0x0000_0013 two cycles after the pulse → mem_rmask=F for exactly one cycle, then imem_resp=1 with imem_rdata=0x0000_0013, and dmem_resp stays 0.
- Store: dmem_wmask=4'h3, addr=0x20, wdata=0xDEADBEEF → mem_wmask=3, mem_wdata=0xDEADBEEF for one cycle, mem_rmask=0, then dmem_resp pulses once.
- Contention: imem and dmem both pending continuously, 1-cycle memory → grant order D,D,D,D,I,D,D,D,D,I with MAX_D_STREAK=4, and no requester ever sees a double resp.
- Held-request in resp cycle: imem keeps its rmask high through and after imem_resp with a new addr 0x1000_0004 → exactly one new issue, at 0x1000_0004, two cycles after the resp.
- Reset mid-WAIT_D: assert rst one cycle, then memory delivers mem_resp → no dmem_resp; all mem_* outputs are 0 after reset, and a re-presented load completes normally.
- Stale response in IDLE: pulse mem_resp with no requests → no resp outputs, state stays IDLE, d_streak stays 0.
